// File: rtl/riscv_pkg.sv
// Shared datapath constants for the single-issue RISC-V pipeline.
package riscv_pkg;

  localparam int          XLEN             = 64;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [63:0] RESET_PC_DEFAULT = 64'd0;

  // Next-PC source chosen by the program counter each cycle.
  typedef enum logic [1:0] {
    PC_HOLD,
    PC_SEQ,
    PC_REDIRECT
  } pc_sel_e;

endpackage : riscv_pkg

// File: rtl/program_counter.sv
// Program counter register with next-PC selection and redirect misalignment detect.
module program_counter
  import riscv_pkg::*;
#(
  parameter int               XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = riscv_pkg::RESET_PC_DEFAULT[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  pc_sel_e         pc_sel;
  logic [XLEN-1:0] aligned_target;

  // Redirect targets are forced to a word boundary; the dropped bits raise the flag.
  assign aligned_target = {redirect_target[XLEN-1:2], 2'b00};
  assign pc_plus4       = pc + FOUR;

  // Next-PC source: redirect beats stall, stall beats sequential advance.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves pc_sel unassigned (no latch).
    pc_sel = PC_SEQ;
    if (redirect_valid) begin
      pc_sel = PC_REDIRECT;
    end else if (stall) begin
      pc_sel = PC_HOLD;
    end
  end

  // PC register and the one-cycle misalignment pulse.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      pc         <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      unique case (pc_sel)
        PC_REDIRECT: begin
          pc         <= aligned_target;
          misaligned <= |redirect_target[1:0];
        end
        PC_HOLD: begin
          misaligned <= 1'b0;
        end
        default: begin
          pc         <= pc_plus4;
          misaligned <= 1'b0;
        end
      endcase
    end
  end

endmodule : program_counter

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the instruction memory and holds the IF/ID register.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int               XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = riscv_pkg::RESET_PC_DEFAULT[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [31:0]     if_instr,
  output logic            if_misaligned
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;

  program_counter #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_program_counter (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .misaligned      (if_misaligned)
  );

  // Memory is addressed by word index; the read returns in the same cycle.
  assign imem_addr = {2'b00, pc[XLEN-1:2]};

  // IF/ID register: a redirect turns the wrong-path slot into a bubble, a stall freezes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_pc_plus4 <= XLEN'(4);
      if_instr    <= NOP_INSTR;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (!stall) begin
      if_valid    <= 1'b1;
      if_pc       <= pc;
      if_pc_plus4 <= pc_plus4;
      if_instr    <= imem_data;
    end
  end

endmodule : fetch_unit

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-issue RISC-V datapath. It holds the program counter, drives the word address into `instruction_memory`, and registers the returned instruction into the IF/ID pipeline register for decode. Execute-stage redirects (branch taken, `jal`, `jalr`) and stalls are accepted here. A redirect flushes the wrong-path instruction as a bubble.

## Interface
Parameters:
- `XLEN`, 64: PC and address width.
- `RESET_PC`, 64'd0: byte address of the first fetch after reset.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hold the PC and IF/ID contents (decode not ready).
- `redirect_valid`  in  1: execute stage resolved a taken control transfer.
- `redirect_target`  in  XLEN: byte address of the redirect.
- `imem_addr`  out  XLEN: word index to `instruction_memory`, equal to `pc >> 2`.
- `imem_data`  in  32: instruction word, combinational from memory.
- `if_valid`  out  1: IF/ID holds a real instruction.
- `if_pc`  out  XLEN: byte PC of `if_instr`.
- `if_pc_plus4`  out  XLEN: `if_pc + 4`, used as the `jal`/`jalr` link value.
- `if_instr`  out  32: registered instruction.
- `if_misaligned`  out  1: one-cycle pulse when an accepted redirect target had `[1:0] != 0`.

## Operation
- PC register `pc` is the byte address. `imem_addr = {2'b00, pc[XLEN-1:2]}` is combinational. Memory read is combinational, so `imem_data` is valid in the same cycle.
- Each edge, priority order:
  1. `reset` asserted (async): `pc=RESET_PC`, `if_valid=0`, `if_pc=0`, `if_pc_plus4=4`, `if_instr=NOP` (32'h00000013), `if_misaligned=0`.
  2. `redirect_valid`: `pc <= {redirect_target[XLEN-1:2],2'b00}`; `if_valid <= 0`; `if_instr <= NOP`; `if_misaligned <= |redirect_target[1:0]`. Redirect wins over `stall`.
  3. `stall`: PC and all IF/ID outputs hold; `if_misaligned <= 0`.
  4. Otherwise: `if_instr <= imem_data`, `if_pc <= pc`, `if_pc_plus4 <= pc+4`, `if_valid <= 1`, `pc <= pc+4`, `if_misaligned <= 0`.
- Arithmetic is modulo 2^XLEN. PC `2^64-4` advances to 0 with no flag.
- `if_pc_plus4` is always `if_pc + 4`, including while flushed.
- No instruction decoding occurs here. Illegal or zero words pass through unchanged.

## Timing
- Fetch latency: the instruction at `pc` appears on `if_instr` one edge after `pc` is presented.
- First valid: `if_valid=1` on the first edge after `reset` deasserts (with no stall or redirect).
- Redirect penalty: one bubble. The edge that samples `redirect_valid` produces `if_valid=0`. The next non-stalled edge delivers the instruction at the target.
- Stall: combinational `imem_addr` stays constant while `stall=1`. Outputs are frozen for exactly the stalled cycles.
- Reset mid-operation: outputs go to reset values immediately (async), without waiting for `clk`. Release is synchronous in effect: the first update happens on the first edge with `reset=0`.
- Simultaneous `redirect_valid` and `stall`: the redirect is taken and the bubble is inserted. The stalling consumer sees `if_valid=0`, so nothing is lost.

## Structure
- Shared package `riscv_pkg` holds `XLEN`, `NOP_INSTR` (32'h00000013) and `RESET_PC_DEFAULT`. Decode and execute reuse these.
- One sub-module is natural: `program_counter`, the PC register plus next-PC selection (reset / redirect / hold / +4) with its misalignment detect.
- `fetch_unit` instantiates `program_counter` and contains the IF/ID register.

## Test plan
- Reset release with `RESET_PC=0` and memory word0=32'h00F00113: `imem_addr=0`. After 1 edge: `if_valid=1`, `if_pc=0`, `if_instr=32'h00F00113`, `if_pc_plus4=4`.
- Sequential run of 4 edges: `if_pc` takes 0,4,8,12 and `imem_addr` takes 1,2,3,4. `if_instr` matches memory words 0..3.
- Redirect at `if_pc=40` (`jal x8,16`) with `redirect_target=56`: next edge gives `if_valid=0`, `if_instr=NOP`, `imem_addr=14`. The following edge gives `if_pc=56`, `if_instr=32'h04B00493`.
- `stall=1` held for 3 cycles at `pc=20`: all outputs and `imem_addr=5` are constant. On release, `if_pc=20`.
- `redirect_valid=1`, `stall=1`, target 32'h2E: `if_valid=0`, `if_misaligned=1` for exactly one cycle, `pc=32'h2C`, `imem_addr=11`.
- `reset` pulsed asynchronously between edges while `if_valid=1`, `pc=60`: outputs go to reset values before the next edge. Fetch resumes at `RESET_PC`.
